video_fetch_seq: RTL and testbench

//  Sequences the four bit-plane shift registers of the video output path.
//  Per 8-pixel group it fetches one byte from each of 4 VRAM planes and

---
 rtl/video_fetch_seq.sv | 188 ++++++++++++++++++
 tb/tb_video_fetch_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fetch_seq.sv
// video_fetch_seq
//   Fetch sequencer for the four bit-plane shift registers of the video
//   output path. For each 8-pixel group it reads one byte per plane from
//   VRAM into a holding buffer while the current group shifts out. At every
//   group boundary it parallel-loads all four shift registers together.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   pix_ce                pixel clock enable (one pixel per asserted cycle)
//   line_start, row[7:0]  new-line pulse and the (scrolled) VRAM row
//   active                visible window, sampled on pix_ce cycles
//   ram_req, ram_addr     VRAM read request, {1, plane, col, row}
//   ram_ack, ram_rdata    read completion pulse and its data
//   shreg_din[31:0]       {plane3, plane2, plane1, plane0} load word
//   shreg_wr, shreg_ce    parallel-load strobe / shift enable (registered)
//   underrun              sticky: a load found the buffer not full
module video_fetch_seq #(
  parameter int PLANES = 4,
  parameter int COLS   = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_ce,
  input  logic        line_start,
  input  logic [7:0]  row,
  input  logic        active,
  output logic        ram_req,
  output logic [15:0] ram_addr,
  input  logic        ram_ack,
  input  logic [7:0]  ram_rdata,
  output logic [31:0] shreg_din,
  output logic        shreg_wr,
  output logic        shreg_ce,
  output logic        underrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_FULL} state_t;

  localparam logic [1:0] LAST_PLANE = 2'(PLANES - 1);
  localparam logic [4:0] LAST_COL   = 5'(COLS - 1);

  state_t      state_q, state_d;
  logic [4:0]  col_q, col_d;
  logic [1:0]  plane_q, plane_d;
  logic [7:0]  row_q, row_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  plane_buf_q [PLANES];
  logic [7:0]  plane_buf_d [PLANES];
  logic        discard_q, discard_d;
  logic        done_q, done_d;
  logic        req_q, req_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic        wr_q, wr_d;
  logic        ce_q, ce_d;
  logic        underrun_q, underrun_d;

  logic [8*PLANES-1:0] load_word;
  logic                load;
  logic                busy;

  // Buffer bytes packed with plane 0 in the low byte.
  for (genvar gi = 0; gi < PLANES; gi++) begin : g_pack
    assign load_word[gi*8 +: 8] = plane_buf_q[gi];
  end

  assign load = pix_ce & active & (bitcnt_q == 3'd0);
  // A request is still waiting for its acknowledge this cycle.
  assign busy = req_q & ~ram_ack;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    plane_d     = plane_q;
    row_d       = row_q;
    bitcnt_d    = bitcnt_q;
    plane_buf_d = plane_buf_q;
    discard_d   = discard_q;
    done_d      = done_q;
    req_d       = req_q;
    addr_d      = addr_q;
    din_d       = din_q;
    wr_d        = 1'b0;
    ce_d        = 1'b0;
    underrun_d  = underrun_q;

    // Pixel sequencing: load on bit 0, shift on bits 1..7.
    if (pix_ce) begin
      if (!active) begin
        bitcnt_d = 3'd0;
      end else begin
        bitcnt_d = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd0) wr_d = 1'b1;
        else                  ce_d = 1'b1;
      end
    end

    // Read completion. Data of a request that straddled a line_start is dropped.
    if (req_q && ram_ack) begin
      req_d     = 1'b0;
      discard_d = 1'b0;
      if (!discard_q) begin
        plane_buf_d[plane_q] = ram_rdata;
        if (plane_q == LAST_PLANE) state_d = ST_FULL;
        else                       plane_d = plane_q + 2'd1;
      end
    end

    // Group boundary: consume the buffer or report the shortfall.
    if (load) begin
      if (state_q == ST_FULL) begin
        din_d   = load_word;
        plane_d = 2'd0;
        if (col_q == LAST_COL) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_FETCH;
          col_d   = col_q + 5'd1;
        end
      end else begin
        din_d = '0;
        // Past the last column the zeros are border fill.
        if (!done_q) underrun_d = 1'b1;
      end
    end

    if (line_start) begin
      row_d    = row;
      col_d    = 5'd0;
      plane_d  = 2'd0;
      bitcnt_d = 3'd0;
      state_d  = ST_FETCH;
      done_d   = 1'b0;
      for (int i = 0; i < PLANES; i++) plane_buf_d[i] = '0;
      // An outstanding request must still complete; its data is stale.
      discard_d = busy;
    end

    // Issue the next plane as soon as the port is free.
    if (state_d == ST_FETCH && !busy) begin
      req_d  = 1'b1;
      addr_d = {1'b1, plane_d, col_d, row_d};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      plane_q    <= '0;
      row_q      <= '0;
      bitcnt_q   <= '0;
      for (int i = 0; i < PLANES; i++) plane_buf_q[i] <= '0;
      discard_q  <= 1'b0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      wr_q       <= 1'b0;
      ce_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      plane_q     <= plane_d;
      row_q       <= row_d;
      bitcnt_q    <= bitcnt_d;
      plane_buf_q <= plane_buf_d;
      discard_q   <= discard_d;
      done_q      <= done_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      wr_q        <= wr_d;
      ce_q        <= ce_d;
      underrun_q  <= underrun_d;
    end
  end

  assign ram_req   = req_q;
  assign ram_addr  = addr_q;
  assign shreg_din = din_q;
  assign shreg_wr  = wr_q;
  assign shreg_ce  = ce_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_video_fetch_seq.sv
// tb_video_fetch_seq
//   Directed bench for video_fetch_seq. A VRAM responder acknowledges each
//   request after a programmable delay and returns A1 + 11*plane + col, so
//   column c loads {D4+c, C3+c, B2+c, A1+c}. A monitor logs every load.
module tb_video_fetch_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pix_ce;
  logic        line_start;
  logic [7:0]  row;
  logic        active;
  logic        ram_req;
  logic [15:0] ram_addr;
  logic        ram_ack;
  logic [7:0]  ram_rdata;
  logic [31:0] shreg_din;
  logic        shreg_wr;
  logic        shreg_ce;
  logic        underrun;

  int n_checks = 0;
  int n_fails  = 0;

  int ack_dly  = 2;
  int long_col = -1;

  logic [15:0] addr_log [$];
  logic [31:0] wr_din   [$];
  logic        wr_unr   [$];
  int          ce_run   [$];
  int          ce_cnt   = 0;

  always #5 clk = ~clk;

  video_fetch_seq #(.PLANES(4), .COLS(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_ce     (pix_ce),
    .line_start (line_start),
    .row        (row),
    .active     (active),
    .ram_req    (ram_req),
    .ram_addr   (ram_addr),
    .ram_ack    (ram_ack),
    .ram_rdata  (ram_rdata),
    .shreg_din  (shreg_din),
    .shreg_wr   (shreg_wr),
    .shreg_ce   (shreg_ce),
    .underrun   (underrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] grp(input int c);
    logic [7:0] cb, b0, b1, b2, b3;
    cb = 8'(c);
    b0 = 8'hA1 + cb;
    b1 = 8'hB2 + cb;
    b2 = 8'hC3 + cb;
    b3 = 8'hD4 + cb;
    return {b3, b2, b1, b0};
  endfunction

  // VRAM responder.
  initial begin
    logic [15:0] a;
    int d;
    ram_ack   = 1'b0;
    ram_rdata = 8'h00;
    forever begin
      @(negedge clk);
      ram_ack = 1'b0;
      if (ram_req && reset_n) begin
        a = ram_addr;
        addr_log.push_back(a);
        d = (int'(a[12:8]) == long_col && a[14:13] == 2'd0) ? 40 : ack_dly;
        repeat (d) @(negedge clk);
        ram_ack   = 1'b1;
        ram_rdata = 8'hA1 + 8'h11 * 8'(a[14:13]) + 8'(a[12:8]);
      end
    end
  end

  // Load / shift monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (shreg_wr || shreg_ce)
        check("wr_ce_excl", {31'b0, shreg_wr & shreg_ce}, 32'd0);
      if (shreg_wr) begin
        $display("load %0d din=%h underrun=%0d", wr_din.size(), shreg_din, underrun);
        wr_din.push_back(shreg_din);
        wr_unr.push_back(underrun);
        ce_run.push_back(ce_cnt);
        ce_cnt = 0;
      end
      if (shreg_ce) ce_cnt++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_line(input logic [7:0] r);
    row        = r;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic pixel(input int period);
    pix_ce = 1'b1;
    @(negedge clk);
    pix_ce = 1'b0;
    repeat (period - 1) @(negedge clk);
  endtask

  task automatic wait_log(input string tag, input int n);
    int budget;
    budget = 400;
    while (addr_log.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check(tag, addr_log.size(), n);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"}, {31'b0, ram_req}, 32'd0);
    check({tag, "_addr"}, {16'b0, ram_addr}, 32'd0);
    check({tag, "_din"}, shreg_din, 32'd0);
    check({tag, "_wr"}, {31'b0, shreg_wr}, 32'd0);
    check({tag, "_ce"}, {31'b0, shreg_ce}, 32'd0);
    check({tag, "_unr"}, {31'b0, underrun}, 32'd0);
  endtask

  initial begin
    int found;
    int req_seen;
    reset_n    = 1'b0;
    pix_ce     = 1'b0;
    line_start = 1'b0;
    row        = 8'h00;
    active     = 1'b0;
    cycles(3);
    check_idle_outputs("reset");
    reset_n = 1'b1;
    cycles(2);

    // 1: plane fetch order for row 0x12.
    pulse_line(8'h12);
    wait_log("t1_nreq", 4);
    cycles(10);
    check("t1_a0", {16'b0, addr_log[0]}, 32'h8012);
    check("t1_a1", {16'b0, addr_log[1]}, 32'hA012);
    check("t1_a2", {16'b0, addr_log[2]}, 32'hC012);
    check("t1_a3", {16'b0, addr_log[3]}, 32'hE012);
    check("t1_full_no_req", {31'b0, ram_req}, 32'd0);
    check("t1_full_nlog", addr_log.size(), 4);

    // 2: first group load, shifts, and column 1 fetch.
    active = 1'b1;
    for (int i = 0; i < 9; i++) pixel(4);
    check("t2_nload", wr_din.size(), 2);
    check("t2_load0", wr_din[0], 32'hD4C3B2A1);
    check("t2_ce_run", ce_run[1], 7);
    check("t2_load1", wr_din[1], 32'hD5C4B3A2);
    check("t2_col1_a0", {16'b0, addr_log[4]}, 32'h8112);
    check("t2_col1_a3", {16'b0, addr_log[7]}, 32'hE112);

    // 3: rest of the line plus 16 border pixels.
    for (int i = 9; i < 272; i++) pixel(4);
    cycles(4);
    active = 1'b0;
    check("t3_nload", wr_din.size(), 34);
    for (int c = 0; c < 32; c++) check($sformatf("t3_load%0d", c), wr_din[c], grp(c));
    check("t3_load32", wr_din[32], 32'd0);
    check("t3_load33", wr_din[33], 32'd0);
    check("t3_nfetch", addr_log.size(), 128);
    check("t3_ce_run", ce_run[33], 7);
    check("t3_underrun", {31'b0, underrun}, 32'd0);

    // 4: column 5 acknowledge held off 40 clocks, pixel every clock.
    cycles(4);
    wr_din.delete();
    wr_unr.delete();
    ce_run.delete();
    addr_log.delete();
    ack_dly  = 0;
    long_col = 5;
    pulse_line(8'h40);
    wait_log("t4_nreq", 4);
    cycles(4);
    active = 1'b1;
    for (int i = 0; i < 120; i++) pixel(1);
    active = 1'b0;
    cycles(4);
    check("t4_nload", wr_din.size(), 15);
    check("t4_load4", wr_din[4], grp(4));
    check("t4_unr_before", {31'b0, wr_unr[4]}, 32'd0);
    check("t4_load5_zero", wr_din[5], 32'd0);
    check("t4_unr_after", {31'b0, wr_unr[5]}, 32'd1);
    found = 0;
    for (int i = 6; i < wr_din.size(); i++) if (wr_din[i] == grp(5)) found = 1;
    check("t4_col5_late", found, 1);
    check("t4_underrun_sticky", {31'b0, underrun}, 32'd1);

    // 5: line_start while the plane 2 request is outstanding.
    long_col = -1;
    ack_dly  = 6;
    cycles(60);
    addr_log.delete();
    pulse_line(8'h77);
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      @(negedge clk);
      if (ram_req && ram_addr[14:13] == 2'd2) found = 1;
    end
    check("t5_p2_seen", found, 1);
    pulse_line(8'h99);
    check("t5_req_held", {31'b0, ram_req}, 32'd1);
    check("t5_addr_held", {16'b0, ram_addr}, 32'hC077);
    wait_log("t5_nreq", 7);
    check("t5_restart_a0", {16'b0, addr_log[3]}, 32'h8099);
    check("t5_restart_a2", {16'b0, addr_log[5]}, 32'hC099);
    check("t5_restart_a3", {16'b0, addr_log[6]}, 32'hE099);
    cycles(10);
    wr_din.delete();
    active = 1'b1;
    pixel(1);
    active = 1'b0;
    cycles(2);
    check("t5_nload", wr_din.size(), 1);
    check("t5_load", wr_din[0], 32'hD4C3B2A1);

    // 6: asynchronous reset in mid-line.
    cycles(30);
    pulse_line(8'h55);
    cycles(5);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_outputs("t6_async");
    @(negedge clk);
    reset_n = 1'b1;
    addr_log.delete();
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_req) req_seen++;
    end
    check("t6_idle_req", req_seen, 0);
    check("t6_idle_nlog", addr_log.size(), 0);
    pulse_line(8'h01);
    wait_log("t6_nreq", 1);
    check("t6_restart_a0", {16'b0, addr_log[0]}, 32'h8001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
